// File: rtl/game_pkg.sv
// Shared definitions for the game sequencer: state encoding and parameter defaults.
package game_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StPlay    = 3'd1,
    StCrash   = 3'd2,
    StRespawn = 3'd3,
    StOver    = 3'd4
  } game_state_e;

  localparam int unsigned LIVES_DEFAULT       = 3;
  localparam int unsigned CRASH_TICKS_DEFAULT = 8;
  localparam int unsigned SCORE_W_DEFAULT     = 6;

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for a level input; a pulse needs the input seen low since reset.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic pulse
);

  logic prev_q;
  logic armed_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      prev_q <= in;
      // A level already high when reset ends must not count as a press.
      if (!in) armed_q <= 1'b1;
    end
  end

  assign pulse = in & ~prev_q & armed_q;

endmodule

// File: rtl/game_sequencer.sv
// Game flow controller: idle, play, crash animation, respawn and game-over handling
// with score and lives bookkeeping.
module game_sequencer
  import game_pkg::*;
#(
  parameter int unsigned LIVES       = LIVES_DEFAULT,
  parameter int unsigned CRASH_TICKS = CRASH_TICKS_DEFAULT,
  parameter int unsigned SCORE_W     = SCORE_W_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               colision,
  input  logic               tick,
  input  logic               sec_tick,
  output logic               run,
  output logic               drop_en,
  output logic               respawn,
  output logic               flash,
  output logic [SCORE_W-1:0] score,
  output logic [1:0]         lives,
  output logic               game_over,
  output logic [2:0]         state
);

  localparam int unsigned CntW = $clog2(CRASH_TICKS + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(CRASH_TICKS - 1);
  localparam logic [SCORE_W-1:0] ScoreMax = {SCORE_W{1'b1}};
  localparam logic [1:0] LivesInit = 2'(LIVES);

  game_state_e        state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [1:0]         lives_q, lives_d;
  logic [CntW-1:0]    crash_cnt_q, crash_cnt_d;
  logic               flash_q, flash_d;
  logic               respawn_q, respawn_d;
  logic               start_pulse;
  logic               crash_done;

  rise_detect u_start_edge (
    .clk   (clk),
    .reset (reset),
    .in    (start),
    .pulse (start_pulse)
  );

  assign crash_done = tick && (crash_cnt_q == CntLast);

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      score_q     <= '0;
      lives_q     <= 2'd0;
      crash_cnt_q <= '0;
      flash_q     <= 1'b0;
      respawn_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      score_q     <= score_d;
      lives_q     <= lives_d;
      crash_cnt_q <= crash_cnt_d;
      flash_q     <= flash_d;
      respawn_q   <= respawn_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StOver: begin
        if (start_pulse) state_d = StPlay;
      end
      StPlay: begin
        if (colision) state_d = StCrash;
      end
      StCrash: begin
        if (crash_done) state_d = (lives_q == 2'd0) ? StOver : StRespawn;
      end
      StRespawn: begin
        if (!colision) state_d = StPlay;
      end
      default: state_d = StIdle;
    endcase
  end

  // Score, lives, crash counter, flash and respawn updates; all keyed on the current state.
  always_comb begin
    score_d     = score_q;
    lives_d     = lives_q;
    crash_cnt_d = crash_cnt_q;
    flash_d     = flash_q;
    respawn_d   = 1'b0;
    unique case (state_q)
      StIdle, StOver: begin
        if (start_pulse) begin
          score_d = '0;
          lives_d = LivesInit;
          flash_d = 1'b0;
        end
      end
      StPlay: begin
        if (colision) begin
          // Collision beats a simultaneous score tick.
          if (lives_q != 2'd0) lives_d = lives_q - 2'd1;
          crash_cnt_d = '0;
          flash_d     = 1'b0;
        end else if (sec_tick && (score_q != ScoreMax)) begin
          score_d = score_q + 1'b1;
        end
      end
      StCrash: begin
        if (tick) begin
          crash_cnt_d = crash_cnt_q + 1'b1;
          flash_d     = ~flash_q;
          if (crash_done) begin
            flash_d   = 1'b0;
            respawn_d = (lives_q != 2'd0);
          end
        end
      end
      StRespawn: begin
        flash_d = 1'b0;
      end
      default: begin
        flash_d = 1'b0;
      end
    endcase
  end

  // Outputs decoded from the state register.
  always_comb begin
    run       = 1'b0;
    drop_en   = 1'b0;
    game_over = 1'b0;
    unique case (state_q)
      StPlay: begin
        run     = tick;
        drop_en = 1'b1;
      end
      StOver:  game_over = 1'b1;
      default: ;
    endcase
  end

  assign respawn = respawn_q;
  assign flash   = flash_q;
  assign score   = score_q;
  assign lives   = lives_q;
  assign state   = state_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer: a vector table for start-up and scoring, then
// hand-written sequences for crash, respawn, game over, restart and reset corners.
module tb_game_sequencer;

  localparam logic [2:0] SIdle = 3'd0, SPlay = 3'd1, SCrash = 3'd2, SResp = 3'd3, SOver = 3'd4;

  logic       clk = 1'b0;
  logic       reset = 1'b0, start = 1'b0, colision = 1'b0, tick = 1'b0, sec_tick = 1'b0;
  logic       run, drop_en, respawn, flash, game_over;
  logic [5:0] score;
  logic [1:0] lives;
  logic [2:0] state;

  int total = 0;
  int bad   = 0;

  game_sequencer #(
    .LIVES       (3),
    .CRASH_TICKS (8),
    .SCORE_W     (6)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .colision  (colision),
    .tick      (tick),
    .sec_tick  (sec_tick),
    .run       (run),
    .drop_en   (drop_en),
    .respawn   (respawn),
    .flash     (flash),
    .score     (score),
    .lives     (lives),
    .game_over (game_over),
    .state     (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, st, col, tk, stk;
    logic [2:0] e_state;
    logic [5:0] e_score;
    logic [1:0] e_lives;
    logic       e_flash, e_resp, e_over, e_drop, e_run;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic expect_all(input string nm, input logic [2:0] st, input logic [5:0] sc,
                            input logic [1:0] lv, input logic fl, input logic rs,
                            input logic ov, input logic dr, input logic rn);
    chk({nm, ".state"}, 32'(state), 32'(st));
    chk({nm, ".score"}, 32'(score), 32'(sc));
    chk({nm, ".lives"}, 32'(lives), 32'(lv));
    chk({nm, ".flash"}, 32'(flash), 32'(fl));
    chk({nm, ".respawn"}, 32'(respawn), 32'(rs));
    chk({nm, ".game_over"}, 32'(game_over), 32'(ov));
    chk({nm, ".drop_en"}, 32'(drop_en), 32'(dr));
    chk({nm, ".run"}, 32'(run), 32'(rn));
  endtask

  // Drive one cycle of inputs, then sample just after the rising edge.
  task automatic cyc(input logic r, input logic s, input logic c, input logic t, input logic st);
    @(negedge clk);
    reset = r; start = s; colision = c; tick = t; sec_tick = st;
    @(posedge clk);
    #1;
  endtask

  // Ticks 1..7 of a crash; the 8th is applied by the caller.
  task automatic crash_ticks(input string nm, input logic [1:0] lv, input logic [5:0] sc,
                             input logic hold_start);
    for (int k = 1; k <= 7; k++) begin
      cyc(1'b0, hold_start || (k == 3), 1'b0, 1'b1, 1'b1);
      expect_all($sformatf("%s.t%0d", nm, k), SCrash, sc, lv, 1'(k % 2), 1'b0, 1'b0, 1'b0,
                 1'b0);
      if (k == 5) begin
        cyc(1'b0, hold_start, 1'b0, 1'b0, 1'b0);
        expect_all({nm, ".notick"}, SCrash, sc, lv, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      end
    end
  endtask

  initial begin
    //         rst st col tk stk  state  score lives fl rs ov dr rn
    vecs[0] = '{1, 0, 0, 0, 0, SIdle, 6'd0, 2'd0, 0, 0, 0, 0, 0};
    vecs[1] = '{0, 0, 0, 0, 0, SIdle, 6'd0, 2'd0, 0, 0, 0, 0, 0};
    vecs[2] = '{0, 1, 0, 0, 0, SPlay, 6'd0, 2'd3, 0, 0, 0, 1, 0};
    vecs[3] = '{0, 1, 0, 0, 1, SPlay, 6'd1, 2'd3, 0, 0, 0, 1, 0};
    vecs[4] = '{0, 0, 0, 1, 0, SPlay, 6'd1, 2'd3, 0, 0, 0, 1, 1};
    vecs[5] = '{0, 0, 0, 1, 1, SPlay, 6'd2, 2'd3, 0, 0, 0, 1, 1};
    vecs[6] = '{0, 0, 0, 0, 0, SPlay, 6'd2, 2'd3, 0, 0, 0, 1, 0};

    for (int i = 0; i < 7; i++) begin
      cyc(vecs[i].rst, vecs[i].st, vecs[i].col, vecs[i].tk, vecs[i].stk);
      expect_all($sformatf("vec%0d", i), vecs[i].e_state, vecs[i].e_score, vecs[i].e_lives,
                 vecs[i].e_flash, vecs[i].e_resp, vecs[i].e_over, vecs[i].e_drop,
                 vecs[i].e_run);
    end

    // Score saturation.
    for (int i = 0; i < 70; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      if (i == 59) chk("score62", 32'(score), 32'd62);
    end
    chk("score_sat", 32'(score), 32'd63);

    // First crash: collision beats sec_tick.
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    expect_all("crash1", SCrash, 6'd63, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    crash_ticks("crash1", 2'd2, 6'd63, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    expect_all("resp1.entry", SResp, 6'd63, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    expect_all("resp1.hold", SResp, 6'd63, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_all("resp1.hold2", SResp, 6'd63, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_all("resp1.exit", SPlay, 6'd63, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Second crash.
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_all("crash2", SCrash, 6'd63, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    crash_ticks("crash2", 2'd1, 6'd63, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_all("resp2.entry", SResp, 6'd63, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_all("resp2.exit", SPlay, 6'd63, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Third crash with start held high into OVER.
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_all("crash3", SCrash, 6'd63, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    crash_ticks("crash3", 2'd0, 6'd63, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    expect_all("over", SOver, 6'd63, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
      expect_all($sformatf("over.held%0d", i), SOver, 6'd63, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0,
                 1'b0);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_all("over.release", SOver, 6'd63, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_all("restart", SPlay, 6'd0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    expect_all("restart.held", SPlay, 6'd1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Reset in the middle of a crash.
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_all("crash4", SCrash, 6'd1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("crash4.flash", 32'(flash), 32'd1);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    expect_all("reset.mid", SIdle, 6'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Start high through reset needs a low sample before it counts.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_all("post_reset.held", SIdle, 6'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_all("post_reset.held2", SIdle, 6'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_all("post_reset.low", SIdle, 6'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    expect_all("post_reset.start", SPlay, 6'd0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
